sdram_port_arbiter: RTL and testbench
=====================================

# sdram_port_arbiter

Two-requester arbiter and command sequencer in front of the single `cache_ctrl` user port (SDRAM-backed main memory). It lets the AHB-lite memory slave (port 0) and a second master such as a boot loader or DMA (port 1) share the port. For each granted transfer it drives the cache's strobe/busy handshake: issue the command, wait for busy to rise, then wait for busy to fall, and returns read data plus a one-cycle ack.

## Interface
Parameters:
- `ISSUE_TIMEOUT`, 255: cycles in ISSUE without `mem_busy` rising before the transfer is aborted with error (1..255).

Ports:
- `clk`  in  1  system clock; also clocks `cache_ctrl`.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `m0_req`, `m1_req`  in  1  transfer request, held until ack.
- `m0_we`, `m1_we`  in  1  1 = write, 0 = read.
- `m0_addr`, `m1_addr`  in  32  byte address; bits [1:0] ignored.
- `m0_wdata`, `m1_wdata`  in  32  write data.
- `m0_mask`, `m1_mask`  in  4  byte-lane enables.
- `m0_ack`, `m1_ack`  out  1  one-cycle completion pulse.
- `m0_err`, `m1_err`  out  1  timeout flag, valid with ack.
- `rdata`  out  32  read data, shared by both ports, valid with ack.
- `grant`  out  2  one-hot owner of the current transfer; 0 when idle.
- `mem_rd_en`  out  1  read strobe to `cache_ctrl` `i_rd_en`.
- `mem_wr_en`  out  1  write strobe to `i_wr_en`.
- `mem_addr`  out  32  word-aligned address to `i_addr`.
- `mem_wdata`  out  32  to `i_data`.
- `mem_mask`  out  4  to `i_mask`.
- `mem_rdata`  in  32  from `o_data`.
- `mem_busy`  in  1  from `o_busy`.

## Operation
- States: IDLE, ISSUE, WAIT, DONE.
- **IDLE**
  - If `mem_busy`=0 and any req is high: choose a winner, latch its we/addr/wdata/mask, set `grant`, clear the timeout counter, go to ISSUE.
  - If `mem_busy`=1 (cache refresh or flush): stay in IDLE.
- **ISSUE**
  - Drive `mem_rd_en`=!we or `mem_wr_en`=we, held until `mem_busy` is seen high, then go to WAIT.
  - Otherwise increment the counter. When it reaches ISSUE_TIMEOUT-1, set the error flag and go to DONE.
- **WAIT**
  - Strobes are low.
  - When `mem_busy`=0: capture `mem_rdata` into `rdata` (reads only; writes leave `rdata` unchanged), go to DONE.
- **DONE**
  - `mX_ack` is high for the granted port, with `mX_err` = error flag.
  - On error, `rdata` = 0.
  - Update last-grant, clear `grant`, go to IDLE.
- **Address, data and mask**
  - `mem_addr` = {addr[31:2], 2'b00}.
  - `mem_wdata` and `mem_mask` come from the latched copies, stable from ISSUE through DONE.
- **Requester rules**
  - Fields must stay stable while req is high.
  - Req still high in the cycle after ack is a new request.
  - A non-granted req waits. It is never dropped.

## Timing
- Reset values: all acks, errs and strobes 0; `rdata`, `mem_addr`, `mem_wdata`, `mem_mask` 0; `grant` 0; state IDLE; last-grant = port 1.
- Reset mid-transfer: return to IDLE immediately with no ack. `cache_ctrl` shares `rst_n`.
- All outputs are registered or decoded from state/latched registers only; no input-to-output combinational path.
- Latency, req sampled at edge E0:
  - ISSUE occupies cycle E0+1.
  - If busy rises in cycle k and falls in cycle m, ack is high in cycle m+1.
  - Minimum is ack 3 cycles after the sampling edge.
- Back-to-back: at least one IDLE cycle between transfers, so the minimum spacing is 4 cycles.
- `mem_busy` already high on entry to ISSUE counts as seen. The strobe is high for exactly that one cycle.
- Simultaneous req from both ports: arbitration rule below. Grant never changes between IDLE exit and DONE.

## Configuration
- `SDRAM_ARB_RR_EN` defined: round-robin. When both ports request, the winner is the port not equal to last-grant. After reset, port 0 wins first.
- Undefined: fixed priority, port 0 always wins. Port 1 is served only when `m0_req`=0 in the IDLE sampling cycle. Last-grant is unused.

## Test plan
- **Single read:** m0 read addr 0x0000_1006, busy high for 5 cycles, `mem_rdata`=0xDEADBEEF → `mem_addr`=0x0000_1004, `mem_rd_en` high 1+ cycles, `m0_ack` pulse, `rdata`=0xDEADBEEF, `m1_ack` stays 0.
- **Write with mask:** m1 write addr 0x10, data 0x12345678, mask 4'b0011, busy delayed 3 cycles after strobe → `mem_wr_en` held 4 cycles, `mem_mask`=0011 stable through DONE, `m1_ack` once, `m1_err`=0.
- **Contention:** both req continuously, 6 transfers → with `SDRAM_ARB_RR_EN` grants alternate 0,1,0,1,0,1; without it, all 6 go to port 0.
- **Timeout:** ISSUE_TIMEOUT=8, busy never rises → strobe high 8 cycles, then `m0_ack`=1, `m0_err`=1, `rdata`=0, back to IDLE.
- **Busy in IDLE:** `mem_busy` high for 10 cycles while m0 req → no strobe until busy falls, then normal transfer.
- **Mid-transfer reset:** `rst_n` pulled low during WAIT → all outputs 0 asynchronously, no ack; after release, a fresh m0 read completes normally.

Source files
------------

// File: rtl/sdram_port_arbiter.sv
// rtl/sdram_port_arbiter.sv - two-port arbiter and strobe/busy sequencer for the cache_ctrl user port
// Optional round-robin arbitration is enabled with `define SDRAM_ARB_RR_EN (fixed priority to port 0 otherwise).
module sdram_port_arbiter #(
  parameter int ISSUE_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_mask,
  output logic        m0_ack,
  output logic        m0_err,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_mask,
  output logic        m1_ack,
  output logic        m1_err,
  output logic [31:0] rdata,
  output logic [1:0]  grant,
  output logic        mem_rd_en,
  output logic        mem_wr_en,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_mask,
  input  logic [31:0] mem_rdata,
  input  logic        mem_busy
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  localparam logic [7:0] TO_LAST = 8'(ISSUE_TIMEOUT - 1);

  state_t      state;
  logic        we_q;
  logic [7:0]  cnt;
  logic        pick1;
  logic        sel_we;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;
  logic [3:0]  sel_mask;

`ifdef SDRAM_ARB_RR_EN
  logic        last_grant;

  // On contention the port that did not win last time goes first.
  always_comb begin
    pick1 = m1_req && (!m0_req || !last_grant);
  end
`else
  always_comb begin
    pick1 = m1_req && !m0_req;
  end
`endif

  always_comb begin
    sel_we    = pick1 ? m1_we    : m0_we;
    sel_addr  = pick1 ? m1_addr  : m0_addr;
    sel_wdata = pick1 ? m1_wdata : m0_wdata;
    sel_mask  = pick1 ? m1_mask  : m0_mask;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      we_q      <= 1'b0;
      cnt       <= 8'd0;
      m0_ack    <= 1'b0;
      m1_ack    <= 1'b0;
      m0_err    <= 1'b0;
      m1_err    <= 1'b0;
      rdata     <= 32'd0;
      grant     <= 2'b00;
      mem_rd_en <= 1'b0;
      mem_wr_en <= 1'b0;
      mem_addr  <= 32'd0;
      mem_wdata <= 32'd0;
      mem_mask  <= 4'd0;
`ifdef SDRAM_ARB_RR_EN
      last_grant <= 1'b1;
`endif
    end else begin
      m0_ack <= 1'b0;
      m1_ack <= 1'b0;
      m0_err <= 1'b0;
      m1_err <= 1'b0;
      case (state)
        S_IDLE: begin
          // A busy cache (refresh/flush) blocks new commands.
          if (!mem_busy && (m0_req || m1_req)) begin
            grant     <= pick1 ? 2'b10 : 2'b01;
            we_q      <= sel_we;
            mem_addr  <= {sel_addr[31:2], 2'b00};
            mem_wdata <= sel_wdata;
            mem_mask  <= sel_mask;
            mem_rd_en <= !sel_we;
            mem_wr_en <= sel_we;
            cnt       <= 8'd0;
            state     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (mem_busy) begin
            mem_rd_en <= 1'b0;
            mem_wr_en <= 1'b0;
            state     <= S_WAIT;
          end else if (cnt == TO_LAST) begin
            mem_rd_en <= 1'b0;
            mem_wr_en <= 1'b0;
            rdata     <= 32'd0;
            m0_ack    <= grant[0];
            m1_ack    <= grant[1];
            m0_err    <= grant[0];
            m1_err    <= grant[1];
            state     <= S_DONE;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        S_WAIT: begin
          if (!mem_busy) begin
            if (!we_q) rdata <= mem_rdata;
            m0_ack <= grant[0];
            m1_ack <= grant[1];
            state  <= S_DONE;
          end
        end
        S_DONE: begin
`ifdef SDRAM_ARB_RR_EN
          last_grant <= grant[1];
`endif
          grant <= 2'b00;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// tb/tb_sdram_port_arbiter.sv - scoreboard bench for sdram_port_arbiter with a strobe/busy cache model
module tb_sdram_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        m0_req = 0, m0_we = 0, m1_req = 0, m1_we = 0;
  logic [31:0] m0_addr = 0, m0_wdata = 0, m1_addr = 0, m1_wdata = 0;
  logic [3:0]  m0_mask = 0, m1_mask = 0;
  logic        m0_ack, m0_err, m1_ack, m1_err;
  logic [31:0] rdata;
  logic [1:0]  grant;
  logic        mem_rd_en, mem_wr_en;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_mask;
  logic [31:0] mem_rdata = 0;
  logic        model_busy = 0, force_busy = 0;

  always #5 clk = ~clk;

  sdram_port_arbiter #(.ISSUE_TIMEOUT(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_mask(m0_mask),
    .m0_ack(m0_ack), .m0_err(m0_err),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_mask(m1_mask),
    .m1_ack(m1_ack), .m1_err(m1_err),
    .rdata(rdata), .grant(grant),
    .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_mask(mem_mask),
    .mem_rdata(mem_rdata), .mem_busy(model_busy | force_busy)
  );

  typedef struct {
    logic [1:0]  ack;
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  exp_t        q[$];
  int          checks = 0;
  int          errors = 0;
  int          strobe_cnt = 0;
  logic [31:0] last_rdata = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Cache model: after a strobe, wait busy_delay cycles, then hold busy for busy_len cycles.
  int busy_delay = 0, busy_len = 1, mphase = 0, dly = 0, rem = 0;
  bit respond = 1;
  always @(negedge clk) begin
    if (!rst_n) begin
      model_busy = 0;
      mphase = 0;
    end else begin
      case (mphase)
        0: if ((mem_rd_en || mem_wr_en) && respond) begin
             if (busy_delay == 0) begin model_busy = 1; rem = busy_len; mphase = 2; end
             else begin dly = busy_delay; mphase = 1; end
           end
        1: begin
             dly--;
             if (dly == 0) begin model_busy = 1; rem = busy_len; mphase = 2; end
           end
        2: begin
             rem--;
             if (rem == 0) begin model_busy = 0; mphase = 3; end
           end
        default: if (!(mem_rd_en || mem_wr_en)) mphase = 0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (rst_n && (mem_rd_en || mem_wr_en)) strobe_cnt++;
  end

  // Response monitor: every ack is matched against the next expected entry.
  always @(negedge clk) begin
    if (rst_n && (m0_ack || m1_ack)) begin
      if (q.size() == 0) begin
        chk("unexpected_ack", {30'd0, m1_ack, m0_ack}, 32'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("ack_port", {30'd0, m1_ack, m0_ack}, {30'd0, e.ack});
        chk("ack_grant", {30'd0, grant}, {30'd0, e.ack});
        chk("ack_err", {30'd0, m1_err, m0_err}, e.err ? {30'd0, e.ack} : 32'd0);
        chk("ack_rdata", rdata, e.rdata);
      end
    end
  end

  task automatic start(input int port, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] mask,
                       input bit tmo, input bit push);
    exp_t e;
    e.ack   = (port == 1) ? 2'b10 : 2'b01;
    e.err   = tmo;
    e.rdata = tmo ? 32'd0 : (we ? last_rdata : mem_rdata);
    if (push) begin
      q.push_back(e);
      last_rdata = e.rdata;
    end
    strobe_cnt = 0;
    if (port == 1) begin
      m1_we = we; m1_addr = addr; m1_wdata = wdata; m1_mask = mask; m1_req = 1;
    end else begin
      m0_we = we; m0_addr = addr; m0_wdata = wdata; m0_mask = mask; m0_req = 1;
    end
  endtask

  task automatic wait_ack(input int port, output int lat);
    bit seen = 0;
    lat = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      lat++;
      seen = (port == 1) ? m1_ack : m0_ack;
    end
    if (!seen) chk("ack_timeout", 32'd0, 32'd1);
    if (port == 1) m1_req = 0; else m0_req = 0;
  endtask

  initial begin
    int lat;
    int n;
    bit hit;
    repeat (2) @(negedge clk);
    chk("rst_grant", {30'd0, grant}, 32'd0);
    chk("rst_strobes", {30'd0, mem_rd_en, mem_wr_en}, 32'd0);
    chk("rst_acks", {28'd0, m0_ack, m1_ack, m0_err, m1_err}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_mask", {28'd0, mem_mask}, 32'd0);
    rst_n = 1;
    @(negedge clk);

    // Single read, busy high 5 cycles.
    busy_delay = 0; busy_len = 5; mem_rdata = 32'hDEADBEEF;
    start(0, 0, 32'h0000_1006, 32'd0, 4'hF, 0, 1);
    wait_ack(0, lat);
    chk("read_latency", lat, 7);
    chk("read_mem_addr", mem_addr, 32'h0000_1004);
    chk("read_strobes", strobe_cnt, 1);
    @(negedge clk);

    // Minimum latency read from port 1.
    busy_delay = 0; busy_len = 1; mem_rdata = 32'h0BADF00D;
    start(1, 0, 32'h0000_0203, 32'd0, 4'hF, 0, 1);
    wait_ack(1, lat);
    chk("min_latency", lat, 3);
    chk("min_mem_addr", mem_addr, 32'h0000_0200);
    @(negedge clk);

    // Masked write, busy delayed 3 cycles after strobe.
    busy_delay = 3; busy_len = 2; mem_rdata = 32'h5555_AAAA;
    start(1, 1, 32'h0000_0010, 32'h12345678, 4'b0011, 0, 1);
    wait_ack(1, lat);
    chk("write_strobes", strobe_cnt, 4);
    chk("write_mask_done", {28'd0, mem_mask}, 32'h3);
    chk("write_wdata_done", mem_wdata, 32'h12345678);
    chk("write_mem_addr", mem_addr, 32'h0000_0010);
    @(negedge clk);

    // Contention: both requesting for 6 transfers.
    busy_delay = 0; busy_len = 1; mem_rdata = 32'hA5A5_0001;
    for (int i = 0; i < 6; i++) begin
      exp_t e;
`ifdef SDRAM_ARB_RR_EN
      e.ack = (i % 2 == 0) ? 2'b01 : 2'b10;
`else
      e.ack = 2'b01;
`endif
      e.err = 0; e.rdata = 32'hA5A5_0001;
      q.push_back(e);
    end
    last_rdata = 32'hA5A5_0001;
    m0_we = 0; m0_addr = 32'h100; m1_we = 0; m1_addr = 32'h200;
    m0_req = 1; m1_req = 1;
    n = 0;
    for (int i = 0; i < 300 && n < 6; i++) begin
      @(negedge clk);
      if (m0_ack || m1_ack) n++;
    end
    m0_req = 0; m1_req = 0;
    chk("contention_count", n, 6);
    @(negedge clk);

    // Busy in IDLE blocks the strobe.
    force_busy = 1; busy_delay = 0; busy_len = 2; mem_rdata = 32'h0000_CAFE;
    start(0, 0, 32'h0000_0040, 32'd0, 4'hF, 0, 1);
    repeat (10) @(negedge clk);
    chk("idle_busy_no_strobe", strobe_cnt, 0);
    chk("idle_busy_no_grant", {30'd0, grant}, 32'd0);
    force_busy = 0;
    wait_ack(0, lat);
    chk("idle_busy_strobes", strobe_cnt, 1);
    @(negedge clk);

    // Timeout: cache never answers.
    respond = 0;
    start(0, 0, 32'h0000_0080, 32'd0, 4'hF, 1, 1);
    wait_ack(0, lat);
    chk("timeout_strobes", strobe_cnt, 8);
    @(negedge clk);
    chk("timeout_idle_grant", {30'd0, grant}, 32'd0);
    respond = 1;
    @(negedge clk);

    // Reset while waiting for busy to fall.
    busy_delay = 0; busy_len = 20; mem_rdata = 32'h1111_2222;
    start(0, 0, 32'h0000_0300, 32'd0, 4'hF, 0, 0);
    hit = 0;
    for (int i = 0; i < 50 && !hit; i++) begin
      @(negedge clk);
      hit = model_busy && !mem_rd_en && (grant == 2'b01);
    end
    chk("reset_reached_wait", {31'd0, hit}, 32'd1);
    @(negedge clk);
    #2 rst_n = 0;
    #1;
    chk("async_rst_grant", {30'd0, grant}, 32'd0);
    chk("async_rst_outs", {26'd0, mem_rd_en, mem_wr_en, m0_ack, m1_ack, m0_err, m1_err}, 32'd0);
    chk("async_rst_rdata", rdata, 32'd0);
    chk("async_rst_mem_addr", mem_addr, 32'd0);
    m0_req = 0;
    last_rdata = 0;
    repeat (3) @(negedge clk);
    rst_n = 1;
    @(negedge clk);

    busy_delay = 0; busy_len = 3; mem_rdata = 32'h7654_3210;
    start(0, 0, 32'h0000_0404, 32'd0, 4'hF, 0, 1);
    wait_ack(0, lat);
    chk("after_reset_latency", lat, 5);

    repeat (5) @(negedge clk);
    chk("queue_empty", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
